// File: rtl/fp_result_packer.sv
// Packs 32-bit FP adder-tree results from a fall-through FIFO into AXI4-Stream beats,
// framing every pkt_len results as one packet with tlast on its final beat.
//
// state    | meaning
// S_IDLE   | waiting for a nonzero pkt_len to start a packet
// S_ACTIVE | popping results until the packet's remaining count reaches zero
module fp_result_packer #(
    parameter int FP_DATA_WIDTH       = 32,
    parameter int C_M_AXIS_DATA_WIDTH = 256,
    parameter int PKT_LEN_WIDTH       = 16
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic [FP_DATA_WIDTH-1:0]         fifo_dout,
    input  logic                             fifo_empty,
    output logic                             fifo_rd_en,
    input  logic [PKT_LEN_WIDTH-1:0]         pkt_len,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             m_axis_tlast,
    output logic [31:0]                      pkt_count
);
    localparam int LANES      = C_M_AXIS_DATA_WIDTH / FP_DATA_WIDTH;
    localparam int KEEP_W     = C_M_AXIS_DATA_WIDTH / 8;
    localparam int LANE_BYTES = FP_DATA_WIDTH / 8;
    localparam int CNT_W      = $clog2(LANES + 1);
    localparam int IDX_W      = $clog2(LANES);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACTIVE = 1'b1;

    logic [0:0]                            state;
    logic [PKT_LEN_WIDTH-1:0]              rem;
    logic [CNT_W-1:0]                      pack_cnt;
    logic [LANES-1:0][FP_DATA_WIDTH-1:0]   pack;
    logic                                  pack_full;
    logic                                  pack_last;
    logic                                  xfer;
    logic                                  pop;
    logic                                  rem_last;
    logic [CNT_W-1:0]                      cnt_base;
    logic [CNT_W-1:0]                      cnt_next;
    logic [IDX_W-1:0]                      lane_idx;
    logic [KEEP_W-1:0]                     keep_next;

    assign xfer       = pack_full && (!m_axis_tvalid || m_axis_tready);
    assign pop        = (state == S_ACTIVE) && (rem != '0) && !fifo_empty && (!pack_full || xfer);
    assign fifo_rd_en = pop;
    assign rem_last   = (rem == PKT_LEN_WIDTH'(1));

    // A pop coinciding with xfer lands in lane 0 of the pack being emptied this edge.
    assign cnt_base = xfer ? '0 : pack_cnt;
    assign cnt_next = cnt_base + CNT_W'(1);
    assign lane_idx = cnt_base[IDX_W-1:0];

    always_comb begin
        keep_next = '0;
        for (int i = 0; i < LANES; i++) begin
            if (CNT_W'(i) < pack_cnt) keep_next[i*LANE_BYTES +: LANE_BYTES] = '1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= S_IDLE;
            rem   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pkt_len != '0) begin
                        rem   <= pkt_len;
                        state <= S_ACTIVE;
                    end
                end
                default: begin
                    if (pop) begin
                        rem <= rem - PKT_LEN_WIDTH'(1);
                        if (rem_last) state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pack      <= '0;
            pack_cnt  <= '0;
            pack_full <= 1'b0;
            pack_last <= 1'b0;
        end else begin
            if (xfer) begin
                pack      <= '0;
                pack_cnt  <= '0;
                pack_full <= 1'b0;
                pack_last <= 1'b0;
            end
            if (pop) begin
                pack[lane_idx] <= fifo_dout;
                pack_cnt       <= cnt_next;
                pack_full      <= (cnt_next == CNT_W'(LANES)) || rem_last;
                pack_last      <= rem_last;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            pkt_count     <= '0;
        end else begin
            if (xfer) begin
                m_axis_tdata  <= pack;
                m_axis_tkeep  <= keep_next;
                m_axis_tlast  <= pack_last;
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
            end
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast) pkt_count <= pkt_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_fp_result_packer.sv
// Self-checking bench for fp_result_packer: a source FIFO model feeds results, a
// packet-chunking reference model predicts every beat, received beats are compared in order.
module tb_fp_result_packer;
    localparam int LANES = 8;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic [31:0]  fifo_dout;
    logic         fifo_empty;
    logic         fifo_rd_en;
    logic [15:0]  pkt_len;
    logic [255:0] m_axis_tdata;
    logic [31:0]  m_axis_tkeep;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         m_axis_tlast;
    logic [31:0]  pkt_count;

    fp_result_packer dut (
        .aclk(aclk), .aresetn(aresetn),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .pkt_len(pkt_len),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .pkt_count(pkt_count)
    );

    always #5 aclk = ~aclk;

    int checks = 0, errors = 0;
    int cyc = 0, pop_cnt = 0, first_pop = -1, last_pop = -1;
    int ready_pct = 100, gap_pct = 0, model_idx = 0;
    bit gap = 1'b0;

    logic [31:0]  src_q[$], sent[$];
    logic [255:0] rx_data[$], exp_data[$];
    logic [31:0]  rx_keep[$], exp_keep[$];
    logic         rx_last[$], exp_last[$];
    int           rx_cyc[$];

    task automatic drive_fifo();
        fifo_empty = gap || (src_q.size() == 0);
        fifo_dout  = (src_q.size() != 0) ? src_q[0] : 32'h0;
    endtask

    task automatic feed(input int n);
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            src_q.push_back(w);
            sent.push_back(w);
        end
        drive_fifo();
    endtask

    // Reference: each packet of len results is cut into ceil(len/LANES) beats, oldest in lane 0.
    function automatic void model_packets(input int len, input int npkt);
        logic [255:0] d;
        logic [31:0]  k;
        for (int p = 0; p < npkt; p++) begin
            for (int b = 0; b < len; b += LANES) begin
                d = '0;
                k = '0;
                for (int l = 0; l < LANES && (b + l) < len; l++) begin
                    d[32*l +: 32] = sent[model_idx];
                    k[4*l +: 4]   = 4'hF;
                    model_idx++;
                end
                exp_data.push_back(d);
                exp_keep.push_back(k);
                exp_last.push_back((b + LANES) >= len);
            end
        end
    endfunction

    task automatic cycle();
        bit popped;
        @(negedge aclk);
        popped = (fifo_rd_en === 1'b1);
        if (popped) begin
            if (pop_cnt == 0) first_pop = cyc;
            last_pop = cyc;
            pop_cnt++;
        end
        if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
            rx_data.push_back(m_axis_tdata);
            rx_keep.push_back(m_axis_tkeep);
            rx_last.push_back(m_axis_tlast);
            rx_cyc.push_back(cyc);
        end
        @(posedge aclk);
        #1;
        cyc++;
        if (popped && src_q.size() != 0) void'(src_q.pop_front());
        m_axis_tready = ($urandom_range(0, 99) < ready_pct);
        gap           = ($urandom_range(0, 99) < gap_pct);
        drive_fifo();
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < 3000 && rx_data.size() < n; k++) cycle();
        repeat (12) cycle();
    endtask

    task automatic clear_state();
        src_q.delete(); sent.delete();
        rx_data.delete(); rx_keep.delete(); rx_last.delete(); rx_cyc.delete();
        exp_data.delete(); exp_keep.delete(); exp_last.delete();
        model_idx = 0; pop_cnt = 0; first_pop = -1; last_pop = -1;
        gap = 1'b0;
        drive_fifo();
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        ready_pct = 100; gap_pct = 0;
        pkt_len = 16'd0;
        m_axis_tready = 1'b1;
        clear_state();
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        pkt_len = 16'd8;
        clear_state();
        feed(8);
        repeat (2) @(negedge aclk);
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", fifo_rd_en); end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", m_axis_tvalid); end
        checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b want 0", m_axis_tlast); end
        checks++; if (m_axis_tkeep !== 32'h0) begin errors++; $display("FAIL reset_tkeep got %h want 0", m_axis_tkeep); end
        checks++; if (m_axis_tdata !== 256'h0) begin errors++; $display("FAIL reset_tdata got %h want 0", m_axis_tdata); end
        checks++; if (pkt_count !== 32'h0) begin errors++; $display("FAIL reset_pkt_count got %0d want 0", pkt_count); end
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
    endtask

    task automatic test_full_beat();
        logic [31:0] vals [8];
        vals = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                 32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
        do_reset();
        for (int i = 0; i < 8; i++) begin src_q.push_back(vals[i]); sent.push_back(vals[i]); end
        drive_fifo();
        pkt_len = 16'd8;
        model_packets(8, 1);
        drain(1);
        checks++; if (rx_data.size() != 1) begin errors++; $display("FAIL t1_beats got %0d want 1", rx_data.size()); end
        if (rx_data.size() >= 1) begin
            checks++; if (rx_data[0] !== exp_data[0]) begin errors++; $display("FAIL t1_tdata got %h want %h", rx_data[0], exp_data[0]); end
            checks++; if (rx_data[0][31:0] !== 32'h3F800000 || rx_data[0][255:224] !== 32'h41000000) begin errors++; $display("FAIL t1_lane_order got %h", rx_data[0]); end
            checks++; if (rx_keep[0] !== 32'hFFFFFFFF) begin errors++; $display("FAIL t1_tkeep got %h want ffffffff", rx_keep[0]); end
            checks++; if (rx_last[0] !== 1'b1) begin errors++; $display("FAIL t1_tlast got %b want 1", rx_last[0]); end
        end
        checks++; if (pkt_count !== 32'd1) begin errors++; $display("FAIL t1_pkt_count got %0d want 1", pkt_count); end
    endtask

    task automatic test_partial_beat();
        do_reset();
        feed(10);
        pkt_len = 16'd10;
        model_packets(10, 1);
        drain(2);
        checks++; if (rx_data.size() != 2) begin errors++; $display("FAIL t2_beats got %0d want 2", rx_data.size()); end
        for (int i = 0; i < rx_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if (rx_data[i] !== exp_data[i] || rx_keep[i] !== exp_keep[i] || rx_last[i] !== exp_last[i]) begin
                errors++;
                $display("FAIL t2_beat%0d got %h/%h/%b want %h/%h/%b", i, rx_data[i], rx_keep[i], rx_last[i], exp_data[i], exp_keep[i], exp_last[i]);
            end
        end
        if (rx_data.size() == 2) begin
            checks++; if (rx_keep[1] !== 32'h000000FF) begin errors++; $display("FAIL t2_keep1 got %h want 000000ff", rx_keep[1]); end
            checks++; if (rx_data[1][255:64] !== 192'h0) begin errors++; $display("FAIL t2_unfilled got %h want 0", rx_data[1][255:64]); end
            checks++; if (rx_last[0] !== 1'b0 || rx_last[1] !== 1'b1) begin errors++; $display("FAIL t2_tlast got %b%b want 01", rx_last[0], rx_last[1]); end
        end
    endtask

    task automatic test_throughput();
        do_reset();
        feed(64);
        pkt_len = 16'd64;
        model_packets(64, 1);
        drain(8);
        checks++; if (rx_data.size() != 8) begin errors++; $display("FAIL t3_beats got %0d want 8", rx_data.size()); end
        checks++; if (pop_cnt != 64 || (last_pop - first_pop) != 63) begin errors++; $display("FAIL t3_pop_run got %0d pops over %0d cycles want 64 over 64", pop_cnt, last_pop - first_pop + 1); end
        for (int i = 1; i < rx_cyc.size(); i++) begin
            checks++; if (rx_cyc[i] - rx_cyc[i-1] != 8) begin errors++; $display("FAIL t3_spacing%0d got %0d want 8", i, rx_cyc[i] - rx_cyc[i-1]); end
        end
        for (int i = 0; i < rx_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if (rx_data[i] !== exp_data[i] || rx_keep[i] !== exp_keep[i] || rx_last[i] !== exp_last[i]) begin
                errors++;
                $display("FAIL t3_beat%0d got %h/%h/%b want %h/%h/%b", i, rx_data[i], rx_keep[i], rx_last[i], exp_data[i], exp_keep[i], exp_last[i]);
            end
        end
        checks++; if (pkt_count !== 32'd1) begin errors++; $display("FAIL t3_pkt_count got %0d want 1", pkt_count); end
    endtask

    task automatic test_backpressure();
        logic [255:0] held;
        bit           seen, stable;
        do_reset();
        ready_pct = 0;
        m_axis_tready = 1'b0;
        feed(32);
        pkt_len = 16'd32;
        model_packets(32, 1);
        seen = 1'b0; stable = 1'b1; held = '0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (m_axis_tvalid === 1'b1) begin
                if (!seen) held = m_axis_tdata;
                else if (m_axis_tdata !== held || m_axis_tlast !== 1'b0 || m_axis_tkeep !== 32'hFFFFFFFF) stable = 1'b0;
                seen = 1'b1;
            end
        end
        checks++; if (pop_cnt != 16) begin errors++; $display("FAIL t4_stall_pops got %0d want 16", pop_cnt); end
        checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL t4_tvalid_held got %b want 1", m_axis_tvalid); end
        checks++; if (!stable) begin errors++; $display("FAIL t4_stable got changing beat want held %h", held); end
        checks++; if (held !== exp_data[0]) begin errors++; $display("FAIL t4_held_data got %h want %h", held, exp_data[0]); end
        ready_pct = 60;
        drain(4);
        checks++; if (rx_data.size() != 4) begin errors++; $display("FAIL t4_beats got %0d want 4", rx_data.size()); end
        for (int i = 0; i < rx_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if (rx_data[i] !== exp_data[i] || rx_keep[i] !== exp_keep[i] || rx_last[i] !== exp_last[i]) begin
                errors++;
                $display("FAIL t4_beat%0d got %h/%h/%b want %h/%h/%b", i, rx_data[i], rx_keep[i], rx_last[i], exp_data[i], exp_keep[i], exp_last[i]);
            end
        end
        checks++; if (pkt_count !== 32'd1) begin errors++; $display("FAIL t4_pkt_count got %0d want 1", pkt_count); end
    endtask

    task automatic test_reset_inflight();
        do_reset();
        ready_pct = 0;
        m_axis_tready = 1'b0;
        feed(16);
        pkt_len = 16'd8;
        for (int k = 0; k < 40 && m_axis_tvalid !== 1'b1; k++) cycle();
        repeat (4) cycle();
        checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL t5_pre_tvalid got %b want 1", m_axis_tvalid); end
        #2;
        aresetn = 1'b0;
        #1;
        checks++; if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || fifo_rd_en !== 1'b0) begin errors++; $display("FAIL t5_async_clear got v%b l%b rd%b want 000", m_axis_tvalid, m_axis_tlast, fifo_rd_en); end
        checks++; if (pkt_count !== 32'h0) begin errors++; $display("FAIL t5_pkt_count got %0d want 0", pkt_count); end
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        clear_state();
        ready_pct = 100;
        m_axis_tready = 1'b1;
        feed(8);
        model_packets(8, 1);
        drain(1);
        checks++; if (rx_data.size() != 1) begin errors++; $display("FAIL t5_beats got %0d want 1", rx_data.size()); end
        if (rx_data.size() >= 1) begin
            checks++;
            if (rx_data[0] !== exp_data[0] || rx_keep[0] !== exp_keep[0] || rx_last[0] !== 1'b1) begin
                errors++;
                $display("FAIL t5_beat got %h/%h/%b want %h/%h/1", rx_data[0], rx_keep[0], rx_last[0], exp_data[0], exp_keep[0]);
            end
        end
        checks++; if (pkt_count !== 32'd1) begin errors++; $display("FAIL t5_pkt_count_after got %0d want 1", pkt_count); end
    endtask

    task automatic test_zero_len();
        do_reset();
        feed(6);
        pkt_len = 16'd0;
        repeat (20) cycle();
        checks++; if (pop_cnt != 0 || rx_data.size() != 0) begin errors++; $display("FAIL t6_zero got %0d pops %0d beats want 0 0", pop_cnt, rx_data.size()); end
        pkt_len = 16'd3;
        model_packets(3, 2);
        drain(2);
        checks++; if (rx_data.size() != 2) begin errors++; $display("FAIL t6_beats got %0d want 2", rx_data.size()); end
        for (int i = 0; i < rx_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if (rx_data[i] !== exp_data[i] || rx_keep[i] !== 32'h00000FFF || rx_last[i] !== 1'b1) begin
                errors++;
                $display("FAIL t6_beat%0d got %h/%h/%b want %h/00000fff/1", i, rx_data[i], rx_keep[i], rx_last[i], exp_data[i]);
            end
        end
        checks++; if (pkt_count !== 32'd2) begin errors++; $display("FAIL t6_pkt_count got %0d want 2", pkt_count); end
    endtask

    task automatic test_len_change();
        do_reset();
        gap_pct = 30;
        pkt_len = 16'd10;
        cycle();
        pkt_len = 16'd5;
        feed(15);
        model_packets(10, 1);
        model_packets(5, 1);
        drain(3);
        checks++; if (rx_data.size() != 3) begin errors++; $display("FAIL lenchg_beats got %0d want 3", rx_data.size()); end
        for (int i = 0; i < rx_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if (rx_data[i] !== exp_data[i] || rx_keep[i] !== exp_keep[i] || rx_last[i] !== exp_last[i]) begin
                errors++;
                $display("FAIL lenchg_beat%0d got %h/%h/%b want %h/%h/%b", i, rx_data[i], rx_keep[i], rx_last[i], exp_data[i], exp_keep[i], exp_last[i]);
            end
        end
        checks++; if (pkt_count !== 32'd2) begin errors++; $display("FAIL lenchg_pkt_count got %0d want 2", pkt_count); end
    endtask

    task automatic test_random_traffic();
        int len, nbeats;
        for (int r = 0; r < 3; r++) begin
            do_reset();
            len = $urandom_range(1, 40);
            ready_pct = 50;
            gap_pct = 30;
            feed(len * 3);
            pkt_len = 16'(len);
            model_packets(len, 3);
            nbeats = exp_data.size();
            drain(nbeats);
            checks++; if (rx_data.size() != nbeats) begin errors++; $display("FAIL rand%0d_beats len %0d got %0d want %0d", r, len, rx_data.size(), nbeats); end
            for (int i = 0; i < rx_data.size() && i < exp_data.size(); i++) begin
                checks++;
                if (rx_data[i] !== exp_data[i] || rx_keep[i] !== exp_keep[i] || rx_last[i] !== exp_last[i]) begin
                    errors++;
                    $display("FAIL rand%0d_beat%0d got %h/%h/%b want %h/%h/%b", r, i, rx_data[i], rx_keep[i], rx_last[i], exp_data[i], exp_keep[i], exp_last[i]);
                end
            end
            checks++; if (pkt_count !== 32'd3) begin errors++; $display("FAIL rand%0d_pkt_count got %0d want 3", r, pkt_count); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b0;
        pkt_len = 16'd0;
        m_axis_tready = 1'b1;
        fifo_empty = 1'b1;
        fifo_dout = 32'h0;
        test_reset();
        test_full_beat();
        test_partial_beat();
        test_throughput();
        test_backpressure();
        test_reset_inflight();
        test_zero_len();
        test_len_change();
        test_random_traffic();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
